// File: rtl/paddsb_reduce_ctrl.sv
// paddsb_reduce_ctrl
//   Accumulates a burst of packed 4x4-bit signed words into a per-lane
//   saturating sum (PADDSB-style) and hands the result to a consumer.
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     start, len            burst request (len words), accepted only in IDLE
//     busy                  high whenever not IDLE
//     in_valid/in_ready     input word handshake, in_data = 4 packed lanes
//     out_valid/out_ready   result handshake
//     out_data              saturated lane sums, held until the next start
//     out_sat               sticky per-lane overflow flags (bit n = lane n)

// One lane: signed 4-bit add clamped to [-8, 7].
module paddsb_lane (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       ovf
);
    logic [3:0] raw;

    assign raw = a + b;
    // Overflow only when both operands share a sign the result lost.
    assign ovf = (a[3] == b[3]) && (raw[3] != a[3]);
    assign sum = ovf ? (a[3] ? 4'b1000 : 4'b0111) : raw;
endmodule

module paddsb_reduce_ctrl #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [15:0]      out_data,
    output logic [3:0]       out_sat,
    input  logic             out_ready
);
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 4;

    // One-hot so the handshake outputs are direct state flop bits.
    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        ACCUM = 3'b010,
        DONE  = 3'b100
    } state_t;

    state_t                              state;
    logic [NUM_LANES-1:0][LANE_W-1:0]    acc;
    logic [NUM_LANES-1:0][LANE_W-1:0]    in_lanes;
    logic [NUM_LANES-1:0][LANE_W-1:0]    sum;
    logic [NUM_LANES-1:0]                ovf;
    logic [NUM_LANES-1:0]                sat;
    logic [LEN_W-1:0]                    cnt;

    assign in_lanes = in_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            paddsb_lane u_lane (
                .a   (acc[gi]),
                .b   (in_lanes[gi]),
                .sum (sum[gi]),
                .ovf (ovf[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            sat   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        sat   <= '0;
                        cnt   <= len;
                        state <= (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= sum;
                        sat <= sat | ovf;
                        cnt <= cnt - LEN_W'(1);
                        // This transfer is the last one of the burst.
                        if (cnt == LEN_W'(1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = ~state[0];
    assign in_ready  = state[1];
    assign out_valid = state[2];
    assign out_data  = acc;
    assign out_sat   = sat;
endmodule

// File: tb/tb_paddsb_reduce_ctrl.sv
`timescale 1ns/1ps
module tb_paddsb_reduce_ctrl;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic [15:0]      out_data;
    logic [3:0]       out_sat;
    logic             out_ready;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    logic [19:0] sb[$];
    logic        ov_q = 1'b0;

    paddsb_reduce_ctrl #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: integer lane sums clamped to the signed 4-bit range.
    function automatic logic [19:0] model(input logic [15:0] w[$]);
        int                 a[4];
        int                 s;
        logic signed [3:0]  v;
        logic [3:0]         f;
        logic [15:0]        d;
        for (int l = 0; l < 4; l++) a[l] = 0;
        f = '0;
        foreach (w[i]) begin
            for (int l = 0; l < 4; l++) begin
                v = w[i][4*l +: 4];
                s = a[l] + int'(v);
                if (s > 7)  begin s = 7;  f[l] = 1'b1; end
                if (s < -8) begin s = -8; f[l] = 1'b1; end
                a[l] = s;
            end
        end
        for (int l = 0; l < 4; l++) d[4*l +: 4] = a[l][3:0];
        return {d, f};
    endfunction

    // Scoreboard: one expected result per completed burst, popped when
    // out_valid rises. Also watches the handshake invariants every cycle.
    always @(negedge clk) begin
        logic [19:0] e;
        chk("inv_busy", {31'd0, busy}, {31'd0, in_ready | out_valid});
        chk("inv_excl", {31'd0, in_ready & out_valid}, 32'd0);
        if (out_valid && !ov_q) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_data", {16'd0, out_data}, {16'd0, e[19:4]});
                chk("sb_sat",  {28'd0, out_sat},  {28'd0, e[3:0]});
            end
        end
        ov_q = out_valid;
    end

    // Drive one burst from a negedge. gaps: idle cycle before each word.
    // stall: cycles out_ready stays low in DONE. poke: start pulses while
    // busy. rel_start: start raised together with the out_ready handshake.
    task automatic run_burst(input int n, input logic [15:0] w[$], input bit gaps,
                             input int stall, input bit poke, input bit rel_start);
        int          c0;
        int          t;
        logic [15:0] hd;
        logic [3:0]  hs;
        sb.push_back(model(w));
        start = 1'b1;
        len   = n[LEN_W-1:0];
        c0    = cyc;
        @(negedge clk);
        start = 1'b0;
        foreach (w[i]) begin
            if (gaps) begin
                in_valid = 1'b0;
                if (poke && i == 1) begin start = 1'b1; len = 4'd5; end
                @(negedge clk);
                start = 1'b0;
                chk("gap_ready", {31'd0, in_ready}, 32'd1);
            end
            in_valid = 1'b1;
            in_data  = w[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 16'hdead;
        t = 0;
        while (!out_valid && t < 40) begin @(negedge clk); t++; end
        chk("valid_tmo", {31'd0, out_valid}, 32'd1);
        if (!gaps) chk("latency", cyc - c0, n + 1);
        hd = out_data;
        hs = out_sat;
        repeat (stall) begin
            if (poke) begin start = 1'b1; len = 4'd1; end
            @(negedge clk);
            start = 1'b0;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data",  {16'd0, out_data}, {16'd0, hd});
        end
        out_ready = 1'b1;
        if (rel_start) begin start = 1'b1; len = 4'd1; end
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk("idle_busy",  {31'd0, busy}, 32'd0);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("ret_data",   {16'd0, out_data}, {16'd0, hd});
        chk("ret_sat",    {28'd0, out_sat},  {28'd0, hs});
        if (rel_start) begin
            @(negedge clk);
            chk("rel_ignored", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        logic [15:0] w[$];
        int          n;
        rst = 1'b1; start = 1'b0; len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data",  {16'd0, out_data}, 32'd0);
        chk("rst_sat",   {28'd0, out_sat}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        w = {16'h1234, 16'h1111}; run_burst(2, w, 0, 0, 0, 0);
        w = {16'h7777, 16'h1111}; run_burst(2, w, 0, 0, 0, 0);
        w = {16'h8888, 16'hFFFF}; run_burst(2, w, 0, 0, 0, 0);
        w = {16'h7F10, 16'h1F01}; run_burst(2, w, 0, 1, 0, 0);
        w = {16'h3456, 16'h2A1F, 16'h4C70}; run_burst(3, w, 1, 4, 1, 1);
        w = {}; run_burst(0, w, 0, 0, 0, 0);

        // Reset after the first of three words: partial sum discarded.
        start = 1'b1; len = 4'd3;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 16'h7777;
        @(negedge clk);
        in_data = 16'h1111; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_busy",  {31'd0, busy}, 32'd0);
        chk("mid_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_data",  {16'd0, out_data}, 32'd0);
        chk("mid_sat",   {28'd0, out_sat}, 32'd0);
        @(negedge clk);
        w = {16'h0001}; run_burst(1, w, 0, 0, 0, 0);

        // Random bursts, including the maximum length.
        for (int k = 0; k < 6; k++) begin
            n = (k == 0) ? 15 : int'($urandom_range(1, 15));
            w = {};
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            run_burst(n, w, 0, int'($urandom_range(0, 2)), 0, 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/paddsb_reduce_ctrl.md
PADDSB_REDUCE_CTRL -- requirements
Module: paddsb_reduce_ctrl

Interface
REQ-001 Parameter LEN_W, default 4: width of the burst-length input; bursts of 0..2^LEN_W-1 words SHALL be supported.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a reduction burst; sampled only in IDLE.
REQ-005 len  input  LEN_W  number of words in the burst; sampled with start.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 in_valid  input  1  producer has a word on in_data.
REQ-008 in_data  input  16  four packed signed 4-bit lanes: [15:12], [11:8], [7:4], [3:0].
REQ-009 in_ready  output  1  block accepts a word this cycle.
REQ-010 out_valid  output  1  reduction result available.
REQ-011 out_data  output  16  packed saturated lane sums.
REQ-012 out_sat  output  4  sticky per-lane saturation flags; bit 3 = lane [15:12], bit 0 = lane [3:0].
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 FSM states SHALL be IDLE, ACCUM, DONE; one-hot or binary encoding is an implementation choice.
REQ-015 IDLE, start=1, len!=0 -> ACCUM next cycle; accumulator cleared to 0x0000, out_sat cleared, remaining count loaded with len.
REQ-016 IDLE, start=1, len=0 -> DONE next cycle with out_data=0x0000, out_sat=4'b0000.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 in_ready SHALL equal 1 exactly when state=ACCUM; a transfer occurs when in_valid & in_ready.
REQ-019 On each transfer, per lane: acc_lane <= sat(acc_lane + in_lane), with signed 4-bit arithmetic and no carry between lanes.
REQ-020 Lane overflow SHALL be detected when both operands have equal sign bits and the raw 4-bit sum sign differs; the positive overflow result is 4'b0111 and the negative overflow result is 4'b1000; otherwise the result is the raw 4-bit sum.
REQ-021 out_sat[lane] SHALL be set on any overflow in that lane during the burst and held until the next accepted start or reset.
REQ-022 Remaining count SHALL decrement by 1 per transfer; the transfer that brings it to 0 SHALL move the FSM to DONE on the next cycle.
REQ-023 ACCUM with in_valid=0 SHALL hold all state; no timeout.
REQ-024 out_valid SHALL equal 1 exactly in DONE; out_data SHALL equal the accumulator and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 DONE with out_ready=1 -> IDLE next cycle; out_data and out_sat SHALL retain the final values in IDLE until the next start.
REQ-026 Latency: the result SHALL be valid in the cycle after the last transfer; with in_valid held high, a burst of N words SHALL reach DONE N+1 cycles after start.
REQ-027 A start asserted in the same cycle as the DONE->IDLE handshake SHALL be ignored; start is accepted only while state=IDLE.

Reset
REQ-028 rst=1 SHALL force state=IDLE, accumulator=0x0000, out_sat=0, count=0, busy=0, in_ready=0, out_valid=0 on the next edge, regardless of the current state.
REQ-029 Reset asserted mid-burst SHALL discard partial results; no transfer SHALL be accepted in the reset cycle.

Verification
REQ-030 len=2, words 0x1234, 0x1111 back-to-back -> out_data=0x2345, out_sat=0000, out_valid 3 cycles after start.
REQ-031 len=2, words 0x7777, 0x1111 -> out_data=0x7777, out_sat=1111; len=2, words 0x8888, 0xFFFF -> out_data=0x8888, out_sat=1111.
REQ-032 len=2, words 0x7F10, 0x1F01 -> out_data=0x7E11, out_sat=1000 (lane independence, no inter-lane carry).
REQ-033 len=3 with in_valid gaps and out_ready held low 4 cycles in DONE -> in_ready only in ACCUM, out_data stable, a start pulse while busy is ignored, and IDLE follows the out_ready handshake.
REQ-034 len=0 -> DONE in 1 cycle with 0x0000; rst asserted after 1 of 3 words -> IDLE with all outputs 0 next cycle, and a following len=1 burst of 0x0001 yields 0x0001.
